dp_ram_stream_rd: RTL and testbench

//   Read-side master for a dp_ram instance: on a start pulse, reads `len` consecutive words

---
 rtl/dp_ram_stream_rd_pkg.sv | 16 +
 rtl/dp_ram_master_states.svh | 11 +
 rtl/rd_skid_buf.sv | 52 +++++
 rtl/dp_ram_stream_rd.sv | 120 ++++++++++++
 tb/tb_dp_ram_stream_rd.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dp_ram_stream_rd_pkg.sv
// Types and constants for the dp_ram stream reader.
package dp_ram_stream_rd_pkg;

  `include "dp_ram_master_states.svh"

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  // Return buffer depth; the issue credit limit equals this value.
  localparam int unsigned buf_depth = 2;

endpackage

// File: rtl/dp_ram_master_states.svh
// State encodings shared by every dp_ram master (stream reader, stream writer, ...).
// Included inside a package so each master can build its own state enum on top.
`ifndef DP_RAM_MASTER_STATES_SVH
`define DP_RAM_MASTER_STATES_SVH

localparam logic [1:0] ST_IDLE  = 2'd0;
localparam logic [1:0] ST_RUN   = 2'd1;
localparam logic [1:0] ST_DRAIN = 2'd2;
localparam logic [1:0] ST_DONE  = 2'd3;

`endif

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO that absorbs read data returning from the RAM while the
// consumer stalls. The head entry is presented combinationally.
module rd_skid_buf #(
  parameter int data_wd = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [data_wd-1:0] push_data,
  input  logic               pop,
  output logic [1:0]         count,
  output logic [data_wd-1:0] head
);

  logic [data_wd-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_pop;
  logic               do_push;

  // A pop on an empty buffer is dropped; a push into a full buffer is only
  // taken when the head leaves in the same cycle.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy update.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is reset too, because head drives a port whose
      // reset value must read as zero.
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dp_ram_stream_rd.sv
// Read-side master for dp_ram: reads `len` words starting at base_add and
// streams them out with valid/ready, hiding the RAM's 1-cycle read latency.
module dp_ram_stream_rd
  import dp_ram_stream_rd_pkg::*;
#(
  parameter int add_wd  = 4,
  parameter int data_wd = 32,
  parameter int depth   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [add_wd-1:0]  base_add,
  input  logic [add_wd:0]    len,
  output logic               busy,
  output logic               done,
  output logic               ram_cs,
  output logic               ram_rd,
  output logic [add_wd-1:0]  ram_rd_add,
  input  logic [data_wd-1:0] ram_rd_data,
  output logic               out_valid,
  output logic [data_wd-1:0] out_data,
  input  logic               out_ready
);

  localparam logic [add_wd-1:0] last_add = add_wd'(depth - 1);
  localparam logic [1:0]        credits  = 2'(buf_depth);

  state_t              state;
  logic [add_wd-1:0]   addr;
  logic [add_wd:0]     remaining;
  logic                in_flight;
  logic [1:0]          buf_count;
  logic [1:0]          occ;
  logic                pop;
  logic                issue;

  // Words owed to the buffer: already stored plus the one still in the RAM.
  assign occ       = buf_count + {1'b0, in_flight};
  assign out_valid = (buf_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // A read may issue while a buffer slot is guaranteed free at return time;
  // when full, a head leaving this cycle frees the slot.
  assign issue = (state == S_RUN) &&
                 ((occ < credits) || ((occ == credits) && pop));

  assign ram_cs     = issue;
  assign ram_rd     = issue;
  assign ram_rd_add = addr;

  // Marks that ram_rd_data holds a word to capture at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_flight <= 1'b0;
    else        in_flight <= issue;
  end

  // Transfer FSM with address/remaining counters and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= base_add;
            remaining <= len;
            if (len != '0) begin
              state <= S_RUN;
              busy  <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            addr      <= (addr == last_add) ? '0 : addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (add_wd+1)'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finish on the edge that retires the final word.
          if (!in_flight && ((buf_count == 2'd0) || ((buf_count == 2'd1) && pop))) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  rd_skid_buf #(
    .data_wd (data_wd)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight),
    .push_data (ram_rd_data),
    .pop       (pop),
    .count     (buf_count),
    .head      (out_data)
  );

endmodule

// File: tb/tb_dp_ram_stream_rd.sv
// Self-checking bench for dp_ram_stream_rd with a behavioural registered-read RAM.
module tb_dp_ram_stream_rd;

  typedef struct {
    logic [3:0] base;
    logic [4:0] len;
    int         mode;      // out_ready pattern
    bit         restart;   // pulse a second start mid-transfer
    int         exp_lat;   // expected cycles start->done, -1 = not checked
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  base_add;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic        ram_cs;
  logic        ram_rd;
  logic [3:0]  ram_rd_add;
  logic [31:0] ram_rd_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  logic [31:0] mem [16];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] exp_data_q [$];
  logic [3:0]  exp_add_q  [$];

  int rd_cnt, hs_cnt, done_cnt, done_cyc, last_hs, outstanding;
  int busy_chk_cyc = -1;
  logic busy_exp;
  logic prev_stall;
  logic [31:0] prev_data;

  vec_t vec [8];
  vec_t v_rst;
  vec_t v_post;

  dp_ram_stream_rd #(.add_wd(4), .data_wd(32), .depth(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_add    (base_add),
    .len         (len),
    .busy        (busy),
    .done        (done),
    .ram_cs      (ram_cs),
    .ram_rd      (ram_rd),
    .ram_rd_add  (ram_rd_add),
    .ram_rd_data (ram_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered-read RAM: data appears after the edge that samples cs && rd.
  initial for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
  always @(posedge clk) if (ram_cs && ram_rd) ram_rd_data <= mem[ram_rd_add];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return (k < 8) ? ((k % 2) == 0) : (k < 14) ? 1'b0 : 1'b1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Monitor: scoreboard pops, credit rule, stall stability, done bookkeeping.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (ram_cs || ram_rd) check("cs_equals_rd", 64'(ram_cs), 64'(ram_rd));
      if (cyc == busy_chk_cyc) check("busy_after_start", 64'(busy), 64'(busy_exp));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (ram_rd) begin
        rd_cnt++;
        check("no_issue_when_full", 64'(outstanding == 2 && !(out_valid && out_ready)), 64'd0);
        if (exp_add_q.size() == 0) check("extra_read", 64'd1, 64'd0);
        else check("rd_add", 64'(ram_rd_add), 64'(exp_add_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs = cyc;
        if (exp_data_q.size() == 0) check("extra_word", 64'd1, 64'd0);
        else check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_low_at_done", 64'(busy), 64'd0);
      end
      outstanding = outstanding + int'(ram_rd) - int'(out_valid && out_ready);
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
    end
  end

  task automatic clear_counts();
    rd_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
  endtask

  task automatic push_expect(input vec_t v);
    for (int i = 0; i < int'(v.len); i++) begin
      int a;
      a = (int'(v.base) + i) % 16;
      exp_add_q.push_back(4'(a));
      exp_data_q.push_back(32'hA000_0000 + 32'(a));
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int s;
    clear_counts();
    push_expect(v);
    @(posedge clk) #1;
    start = 1'b1; base_add = v.base; len = v.len; out_ready = ready_for(v.mode, 0);
    s = cyc;
    busy_exp = (v.len != 5'd0);
    busy_chk_cyc = s + 1;
    for (int k = 1; k < 400 && done_cnt == 0; k++) begin
      @(posedge clk) #1;
      if (v.restart && k == 2) begin
        start = 1'b1; base_add = 4'd9; len = 5'd3;
      end else begin
        start = 1'b0;
      end
      out_ready = ready_for(v.mode, k);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk) #1;
      start = 1'b0;
      out_ready = 1'b1;
    end
    check("done_count", 64'(done_cnt), 64'd1);
    check("word_count", 64'(hs_cnt), 64'(v.len));
    check("read_count", 64'(rd_cnt), 64'(v.len));
    check("words_left", 64'(exp_data_q.size()), 64'd0);
    if (v.exp_lat >= 0) check("done_latency", 64'(done_cyc - s), 64'(v.exp_lat));
    if (v.len != 5'd0) check("done_after_last_hs", 64'(done_cyc - last_hs), 64'd1);
  endtask

  initial begin
    vec[0] = '{base: 4'd3,  len: 5'd4,  mode: 0, restart: 1'b0, exp_lat: 7};
    vec[1] = '{base: 4'd14, len: 5'd5,  mode: 0, restart: 1'b0, exp_lat: 8};
    vec[2] = '{base: 4'd0,  len: 5'd16, mode: 2, restart: 1'b0, exp_lat: -1};
    vec[3] = '{base: 4'd7,  len: 5'd0,  mode: 0, restart: 1'b0, exp_lat: 1};
    vec[4] = '{base: 4'd5,  len: 5'd6,  mode: 1, restart: 1'b1, exp_lat: -1};
    vec[5] = '{base: 4'd10, len: 5'd16, mode: 3, restart: 1'b0, exp_lat: -1};
    vec[6] = '{base: 4'd15, len: 5'd1,  mode: 0, restart: 1'b0, exp_lat: 4};
    vec[7] = '{base: 4'd0,  len: 5'd16, mode: 0, restart: 1'b0, exp_lat: 19};
    v_rst  = '{base: 4'd0,  len: 5'd8,  mode: 0, restart: 1'b0, exp_lat: -1};
    v_post = '{base: 4'd0,  len: 5'd2,  mode: 0, restart: 1'b0, exp_lat: 5};

    rst_n = 1'b0; start = 1'b0; base_add = '0; len = '0; out_ready = 1'b0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_ram_rd", 64'(ram_rd), 64'd0);
    check("rst_ram_rd_add", 64'(ram_rd_add), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);

    for (int i = 0; i < 8; i++) run_xfer(vec[i]);

    // Reset in the middle of an 8-word transfer, after two words are taken.
    clear_counts();
    push_expect(v_rst);
    @(posedge clk) #1;
    start = 1'b1; base_add = v_rst.base; len = v_rst.len; out_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    for (int k = 0; k < 50 && hs_cnt < 2; k++) @(negedge clk);
    check("pre_reset_words", 64'(hs_cnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ram_rd", 64'(ram_rd), 64'd0);
    check("mid_rst_ram_cs", 64'(ram_cs), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    exp_data_q.delete();
    exp_add_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);
    run_xfer(v_post);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
